cpu_exec_unit: RTL and testbench

CPU_EXEC_UNIT -- requirements
Module: cpu_exec_unit

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/key_debouncer.sv | 44 ++++
 rtl/cpu_exec_unit.sv | 124 ++++++++++++
 tb/tb_cpu_exec_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute unit and the LCD controller:
// opcode encoding, instruction word field positions and immediate helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_ADD   = 3'd1,
        OP_ADDI  = 3'd2,
        OP_SUB   = 3'd3,
        OP_SUBI  = 3'd4,
        OP_MUL   = 3'd5,
        OP_CLEAR = 3'd6,
        OP_DPL   = 3'd7
    } opcode_t;

    localparam int unsigned SW_W     = 18;
    localparam int unsigned OPC_MSB  = 17;
    localparam int unsigned OPC_LSB  = 15;
    localparam int unsigned RD_MSB   = 14;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned RS1_MSB  = 10;
    localparam int unsigned RS1_LSB  = 7;
    localparam int unsigned RS2_MSB  = 6;
    localparam int unsigned RS2_LSB  = 3;
    localparam int unsigned IMM_MSB  = 6;
    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 16;

    function automatic logic [DATA_W-1:0] sext_imm7(input logic [6:0] imm);
        return {{(DATA_W-7){imm[6]}}, imm};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button front end: 2-FF synchronizer, stability counter and
// falling-edge detect producing a one-cycle press pulse.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // stable only follows sync2 after it has differed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_exec_unit.sv
// Single-instruction execute unit: debounced key press runs the instruction
// on sw against a 16x16 register file and reports the result to the LCD.
module cpu_exec_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLDOFF_CYCLES  = 2000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] sw,
    input  logic        key_n,
    output logic        disp_start,
    output logic [2:0]  disp_opcode,
    output logic [3:0]  disp_reg,
    output logic [15:0] disp_value,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, REPORT, HOLD} state_t;

    localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    state_t              state;
    logic                press;
    logic [SW_W-1:0]     instr;
    logic [HW-1:0]       hold_cnt;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    opcode_t             opc;
    logic [3:0]          rd;
    logic [3:0]          rs1;
    logic [3:0]          rs2;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic signed [31:0]  prod;
    logic [DATA_W-1:0]   result;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_n),
        .press   (press)
    );

    always_comb begin
        opc    = opcode_t'(instr[OPC_MSB:OPC_LSB]);
        rd     = instr[RD_MSB:RD_LSB];
        rs1    = instr[RS1_MSB:RS1_LSB];
        rs2    = instr[RS2_MSB:RS2_LSB];
        imm    = sext_imm7(instr[IMM_MSB:IMM_LSB]);
        a      = regs[rs1];
        b      = regs[rs2];
        prod   = $signed(a) * $signed(b);
        result = '0;
        case (opc)
            OP_LOAD:  result = imm;
            OP_ADD:   result = a + b;
            OP_ADDI:  result = a + imm;
            OP_SUB:   result = a - b;
            OP_SUBI:  result = a - imm;
            OP_MUL:   result = prod[DATA_W-1:0];
            OP_CLEAR: result = '0;
            OP_DPL:   result = regs[rd];
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            instr       <= '0;
            hold_cnt    <= '0;
            disp_start  <= 1'b0;
            disp_opcode <= '0;
            disp_reg    <= '0;
            disp_value  <= '0;
            busy        <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            disp_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        instr <= sw;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                // disp_* are loaded here so they are visible during REPORT
                EXEC: begin
                    if (opc == OP_CLEAR) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                    end else if (opc != OP_DPL) begin
                        regs[rd] <= result;
                    end
                    disp_start  <= 1'b1;
                    disp_opcode <= opc;
                    disp_reg    <= rd;
                    disp_value  <= result;
                    state       <= REPORT;
                end
                REPORT: begin
                    hold_cnt <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Directed vector bench for cpu_exec_unit with short debounce/holdoff.
module tb_cpu_exec_unit;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [17:0] sw = '0;
    logic        key_n = 1'b1;
    logic        disp_start;
    logic [2:0]  disp_opcode;
    logic [3:0]  disp_reg;
    logic [15:0] disp_value;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int starts   = 0;

    cpu_exec_unit #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw          (sw),
        .key_n       (key_n),
        .disp_start  (disp_start),
        .disp_opcode (disp_opcode),
        .disp_reg    (disp_reg),
        .disp_value  (disp_value),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (disp_start) starts++;

    typedef struct {
        logic [17:0] sw;
        logic [2:0]  opc;
        logic [3:0]  rd;
        logic [15:0] val;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_instr(input logic [17:0] s, input logic [2:0] eo, input logic [3:0] er,
                            input logic [15:0] ev, input string tag);
        int p_at = -1;
        int s_at = -1;
        logic b_at = 1'b0;
        sw    = s;
        key_n = 1'b0;
        for (int c = 0; c < 40 && s_at < 0; c++) begin
            @(negedge clk);
            if (dut.u_deb.press && p_at < 0) p_at = c;
            if (disp_start) begin
                s_at = c;
                b_at = busy;
            end
        end
        check({tag, " latency"}, s_at - p_at, 32'd2);
        check({tag, " opcode"}, {29'd0, disp_opcode}, {29'd0, eo});
        check({tag, " reg"}, {28'd0, disp_reg}, {28'd0, er});
        check({tag, " value"}, {16'd0, disp_value}, {16'd0, ev});
        check({tag, " busy"}, {31'd0, b_at}, 32'd1);
        key_n = 1'b1;
        wait_idle(tag);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_press(input string tag);
        int n = 0;
        while (!dut.u_deb.press && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, " press seen"}, {31'd0, dut.u_deb.press}, 32'd1);
    endtask

    initial begin
        int s0;
        vecs[0]  = '{{3'd0, 4'd2,  4'd0, 7'h7D},       3'd0, 4'd2,  16'hFFFD};
        vecs[1]  = '{{3'd1, 4'd3,  4'd2, 4'd2, 3'd0},  3'd1, 4'd3,  16'hFFFA};
        vecs[2]  = '{{3'd5, 4'd4,  4'd3, 4'd3, 3'd0},  3'd5, 4'd4,  16'h0024};
        vecs[3]  = '{{3'd3, 4'd10, 4'd2, 4'd3, 3'd0},  3'd3, 4'd10, 16'h0003};
        vecs[4]  = '{{3'd0, 4'd5,  4'd0, 7'h40},       3'd0, 4'd5,  16'hFFC0};
        vecs[5]  = '{{3'd5, 4'd6,  4'd5, 4'd5, 3'd0},  3'd5, 4'd6,  16'h1000};
        vecs[6]  = '{{3'd1, 4'd6,  4'd6, 4'd6, 3'd0},  3'd1, 4'd6,  16'h2000};
        vecs[7]  = '{{3'd1, 4'd6,  4'd6, 4'd6, 3'd0},  3'd1, 4'd6,  16'h4000};
        vecs[8]  = '{{3'd1, 4'd7,  4'd6, 4'd6, 3'd0},  3'd1, 4'd7,  16'h8000};
        vecs[9]  = '{{3'd4, 4'd8,  4'd7, 7'h01},       3'd4, 4'd8,  16'h7FFF};
        vecs[10] = '{{3'd2, 4'd9,  4'd8, 7'h01},       3'd2, 4'd9,  16'h8000};
        vecs[11] = '{{3'd5, 4'd11, 4'd8, 4'd8, 3'd0},  3'd5, 4'd11, 16'h0001};
        vecs[12] = '{{3'd7, 4'd4,  11'd0},             3'd7, 4'd4,  16'h0024};
        vecs[13] = '{{3'd2, 4'd12, 4'd2, 7'h7F},       3'd2, 4'd12, 16'hFFFC};
        vecs[14] = '{{3'd7, 4'd4,  11'd0},             3'd7, 4'd4,  16'h0024};
        vecs[15] = '{{3'd6, 4'd0,  11'd0},             3'd6, 4'd0,  16'h0000};
        vecs[16] = '{{3'd7, 4'd2,  11'd0},             3'd7, 4'd2,  16'h0000};
        vecs[17] = '{{3'd7, 4'd9,  11'd0},             3'd7, 4'd9,  16'h0000};

        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset start", {31'd0, disp_start}, 32'd0);
        check("reset value", {16'd0, disp_value}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 18; i++)
            do_instr(vecs[i].sw, vecs[i].opc, vecs[i].rd, vecs[i].val, $sformatf("vec%0d", i));

        // bouncing key: three short lows then a stable low -> one instruction
        s0 = starts;
        sw = {3'd0, 4'd1, 4'd0, 7'd7};
        for (int i = 0; i < 3; i++) begin
            key_n = 1'b0;
            repeat (2) @(negedge clk);
            key_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        key_n = 1'b0;
        repeat (40) @(negedge clk);
        check("bounce starts", starts - s0, 32'd1);
        check("bounce value", {16'd0, disp_value}, 32'd7);
        for (int i = 0; i < 3; i++) begin
            key_n = 1'b1;
            repeat (2) @(negedge clk);
            key_n = 1'b0;
            repeat (2) @(negedge clk);
        end
        key_n = 1'b1;
        repeat (40) @(negedge clk);
        check("bounce release starts", starts - s0, 32'd1);

        // second press lands inside HOLD and must be dropped
        s0 = starts;
        sw = {3'd7, 4'd1, 11'd0};
        key_n = 1'b0;
        wait_press("hold first");
        key_n = 1'b1;
        repeat (8) @(negedge clk);
        key_n = 1'b0;
        @(negedge clk);
        wait_press("hold second");
        check("hold busy", {31'd0, busy}, 32'd1);
        wait_idle("hold");
        repeat (10) @(negedge clk);
        check("hold starts", starts - s0, 32'd1);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        do_instr({3'd7, 4'd1, 11'd0}, 3'd7, 4'd1, 16'h0007, "after hold");

        // reset during HOLD aborts and clears everything
        do_instr({3'd0, 4'd3, 4'd0, 7'd5}, 3'd0, 4'd3, 16'h0005, "pre reset");
        sw = {3'd0, 4'd3, 4'd0, 7'd7};
        key_n = 1'b0;
        wait_press("rst press");
        repeat (6) @(negedge clk);
        key_n = 1'b1;
        check("rst in hold", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst start", {31'd0, disp_start}, 32'd0);
        check("rst opcode", {29'd0, disp_opcode}, 32'd0);
        check("rst reg", {28'd0, disp_reg}, 32'd0);
        check("rst value", {16'd0, disp_value}, 32'd0);
        for (int i = 0; i < 16; i++)
            check($sformatf("rst r%0d", i), {16'd0, dut.regs[i]}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        s0 = starts;
        repeat (30) @(negedge clk);
        check("rst no start", starts - s0, 32'd0);
        do_instr({3'd7, 4'd3, 11'd0}, 3'd7, 4'd3, 16'h0000, "post reset dpl");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
